hid_report_queue: RTL

HID_REPORT_QUEUE -- requirements
Module: hid_report_queue

---
 rtl/hid_report_queue_if.sv | 26 ++
 rtl/hid_report_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hid_report_queue_if.sv
// hid_report_queue_if
//   Bundles the USB report capture inputs and the CPU read port of
//   hid_report_queue.
//   master : drives usb_type, usb_report, hid_report, cpu_valid,
//            cpu_rdstrb and cpu_sel; receives rdata and not_empty.
//   slave  : the queue itself (mirror of master).
interface hid_report_queue_if;
  logic [1:0]  usb_type;
  logic        usb_report;
  logic [63:0] hid_report;
  logic        cpu_valid;
  logic        cpu_rdstrb;
  logic [1:0]  cpu_sel;
  logic [31:0] rdata;
  logic        not_empty;

  modport master (
    output usb_type, usb_report, hid_report, cpu_valid, cpu_rdstrb, cpu_sel,
    input  rdata, not_empty
  );

  modport slave (
    input  usb_type, usb_report, hid_report, cpu_valid, cpu_rdstrb, cpu_sel,
    output rdata, not_empty
  );
endinterface

// File: rtl/hid_report_queue.sv
// hid_report_queue
//   FIFO of USB HID reports ({type, 64-bit payload}) read by a CPU through
//   a small register window. Selects: 0 status, 1 head payload[31:0],
//   2 head payload[63:32] and pop, 3 reads zero. A read acts once per rising
//   edge of (cpu_valid && cpu_rdstrb); rdata is registered and holds.
//   Ports:
//     clk  - rising-edge clock
//     rstn - asynchronous active-low reset
//     bus  - hid_report_queue_if.slave (usb_*, hid_report, cpu_*, rdata,
//            not_empty)
//   Parameters: DEPTH (power of two, 2..64), OVERWRITE (0 drop newest,
//   1 evict oldest when full), CAPTURE_MASK (per usb_type capture enable).
module hid_report_queue #(
  parameter int         DEPTH        = 4,
  parameter bit         OVERWRITE    = 1'b0,
  parameter logic [3:0] CAPTURE_MASK = 4'b0110
) (
  input logic               clk,
  input logic               rstn,
  hid_report_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [65:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic             rd_act_p1;
  logic [1:0]       usb_type_p1;

  logic             rd_act, rd_evt, flush, is_empty, is_full;
  logic             push_req, pop, drop, wr_en, evict, stat_clr;
  logic [65:0]      head;
  logic [1:0]       head_type;
  logic [31:0]      status_word, rdata_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic             overflow_nxt;
  logic [7:0]       drop_cnt_nxt;

  // ---- stage p0: read edge, flush detect and queue bookkeeping ----
  always_comb begin
    rd_act    = bus.cpu_valid && bus.cpu_rdstrb;
    rd_evt    = rd_act && !rd_act_p1;
    flush     = (usb_type_p1 != 2'd0) && (bus.usb_type == 2'd0);
    is_empty  = (count == '0);
    is_full   = (count == FULL_CNT);
    push_req  = bus.usb_report && CAPTURE_MASK[bus.usb_type];
    // Flush outranks both queue operations.
    pop       = rd_evt && (bus.cpu_sel == 2'd2) && !is_empty && !flush;
    drop      = push_req && is_full && !pop && !flush;
    // When full with a simultaneous pop, the write lands in the slot being
    // freed; with OVERWRITE the write replaces the oldest entry instead.
    wr_en     = push_req && !flush && (!is_full || pop || OVERWRITE);
    evict     = drop && OVERWRITE;
    stat_clr  = rd_evt && (bus.cpu_sel == 2'd0);

    head      = mem[rd_ptr];
    head_type = is_empty ? 2'b00 : head[65:64];
    status_word = {8'h00, drop_cnt, 8'(count), 3'b000, overflow, is_full,
                   !is_empty, head_type};

    rdata_nxt = bus.rdata;
    if (rd_evt) begin
      case (bus.cpu_sel)
        2'd0:    rdata_nxt = status_word;
        2'd1:    rdata_nxt = is_empty ? 32'h0 : head[31:0];
        2'd2:    rdata_nxt = is_empty ? 32'h0 : head[63:32];
        default: rdata_nxt = 32'h0;
      endcase
    end

    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (flush) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end else begin
      if (wr_en && !pop && !evict) count_nxt = count + CNT_W'(1);
      else if (pop && !wr_en)      count_nxt = count - CNT_W'(1);
      if (pop || evict) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (wr_en)        wr_ptr_nxt = wr_ptr + PTR_W'(1);
    end

    // A status read clears the sticky state, but a drop on the same cycle
    // is still recorded.
    overflow_nxt = overflow;
    drop_cnt_nxt = drop_cnt;
    if (stat_clr) begin
      overflow_nxt = drop;
      drop_cnt_nxt = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_nxt = 1'b1;
      drop_cnt_nxt = sat_inc8(drop_cnt);
    end
  end

  // ---- stage p1: registered control and outputs ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      drop_cnt      <= 8'd0;
      rd_act_p1     <= 1'b0;
      usb_type_p1   <= 2'd0;
      bus.rdata     <= 32'h0;
      bus.not_empty <= 1'b0;
    end else begin
      rd_ptr        <= rd_ptr_nxt;
      wr_ptr        <= wr_ptr_nxt;
      count         <= count_nxt;
      overflow      <= overflow_nxt;
      drop_cnt      <= drop_cnt_nxt;
      rd_act_p1     <= rd_act;
      usb_type_p1   <= bus.usb_type;
      bus.rdata     <= rdata_nxt;
      bus.not_empty <= (count_nxt != '0);
    end
  end

  // Report storage is data only; entries are unreachable while count is 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.usb_type, bus.hid_report};
  end

endmodule
